// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART transmit and receive controllers: the frame
// FSM state encoding, the default frame shape (one clock per bit, 8 data bits,
// 1 stop bit) and the idle/start levels of the serial line.
// Ports: none (package only).
// -----------------------------------------------------------------------------
package uart_pkg;

  // Frame sequencing states, common to both link directions.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  // Default frame shape. Both ends of the link must agree on these.
  localparam int DEFAULT_CLKS_PER_BIT = 1;
  localparam int DEFAULT_DATA_BITS    = 8;
  localparam int DEFAULT_STOP_BITS    = 1;

  // The line rests high. A start bit is the only low level outside data.
  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

  // Width of a counter that runs 0..range-1. Never narrower than one bit,
  // so a range of 1 still yields a legal vector.
  function automatic int counterWidth(input int range);
    return (range > 1) ? $clog2(range) : 1;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// -----------------------------------------------------------------------------
// uart_bit_timer
// Divides the clock into serial bit periods of CLKS_PER_BIT cycles. While
// enabled, the counter runs 0..CLKS_PER_BIT-1 and wraps. bit_end is high on the
// last cycle of every bit period. While disabled, the counter is held at zero.
// As a result, the first bit after enable always lasts a full period.
// Ports:
//   clk      rising-edge clock
//   reset    synchronous active-high reset, clears the counter
//   enable   count while high; hold at zero while low
//   bit_end  one-cycle pulse on the final cycle of each bit period
// -----------------------------------------------------------------------------
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic bit_end
);

  localparam int CntW = counterWidth(CLKS_PER_BIT);
  localparam logic [CntW-1:0] LastCount = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] count_q;
  logic [CntW-1:0] count_d;
  logic            atLast;

  // Next count. Wrap to zero at the end of a period. Also fall back to zero
  // whenever counting is disabled, so the period restarts cleanly.
  always_comb begin
    atLast  = (count_q == LastCount);
    count_d = '0;
    if (enable && !atLast) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign bit_end = enable && atLast;

endmodule

// File: rtl/tx_controller.sv
// -----------------------------------------------------------------------------
// tx_controller
// UART transmitter. It takes one parallel word per valid/ready handshake and
// sends it as a frame on a line that idles high: one start bit, then
// DATA_BITS data bits LSB first, then STOP_BITS stop bits. Each serial bit is
// held for CLKS_PER_BIT clocks. All outputs come straight from registers.
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset; aborts any frame in flight
//   i_tx_valid   host offers a word
//   i_tx_data    word to send, sampled only on the accept edge
//   o_tx_ready   a word can be accepted this cycle (only while idle)
//   o_tx_serial  serial line, high when idle
//   o_tx_busy    a frame is in progress (start, data or stop)
//   o_tx_done    one-cycle pulse after the last stop bit completes
// -----------------------------------------------------------------------------
module tx_controller
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEFAULT_DATA_BITS,
  parameter int STOP_BITS    = DEFAULT_STOP_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_tx_valid,
  input  logic [DATA_BITS-1:0] i_tx_data,
  output logic                 o_tx_ready,
  output logic                 o_tx_serial,
  output logic                 o_tx_busy,
  output logic                 o_tx_done
);

  // One index counter serves both the data bits and the stop bits. STOP_BITS
  // is at most 2, so it always fits in the width needed for the data bits.
  localparam int IdxW = counterWidth(DATA_BITS);
  localparam logic [IdxW-1:0] LastDataIdx = IdxW'(DATA_BITS - 1);
  localparam logic [IdxW-1:0] LastStopIdx = IdxW'(STOP_BITS - 1);

  uart_state_e          state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] shift_d;
  logic [IdxW-1:0]      bitIdx_q;
  logic                 serial_q;
  logic                 ready_q;
  logic                 busy_q;
  logic                 done_q;

  logic timerEnable;
  logic bitEnd;

  // The bit timer runs only while a frame is on the line. Entering START from
  // IDLE therefore always begins with a fresh, full-length bit period.
  assign timerEnable = (state_q != IDLE);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (clk),
    .reset  (reset),
    .enable (timerEnable),
    .bit_end(bitEnd)
  );

  // The serial output is a register, so it must be loaded one edge before the
  // bit appears on the line. For that reason the next data bit is read from
  // the already-shifted word, not from the current LSB.
  assign shift_d = shift_q >> 1;

  // Frame sequencer. It owns every output register. o_tx_done is asserted on
  // the same edge that returns to IDLE. ready_q rises on that same edge, so
  // the host can hand over the next word while done is still high.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      bitIdx_q <= '0;
      serial_q <= LINE_IDLE;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_tx_valid && ready_q) begin
            shift_q  <= i_tx_data;
            bitIdx_q <= '0;
            serial_q <= LINE_START;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= START;
          end
        end

        START: begin
          if (bitEnd) begin
            serial_q <= shift_q[0];
            state_q  <= DATA;
          end
        end

        DATA: begin
          if (bitEnd) begin
            if (bitIdx_q == LastDataIdx) begin
              bitIdx_q <= '0;
              serial_q <= LINE_IDLE;
              state_q  <= STOP;
            end else begin
              bitIdx_q <= bitIdx_q + 1'b1;
              shift_q  <= shift_d;
              serial_q <= shift_d[0];
            end
          end
        end

        STOP: begin
          if (bitEnd) begin
            if (bitIdx_q == LastStopIdx) begin
              bitIdx_q <= '0;
              ready_q  <= 1'b1;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              state_q  <= IDLE;
            end else begin
              bitIdx_q <= bitIdx_q + 1'b1;
            end
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_tx_ready  = ready_q;
  assign o_tx_serial = serial_q;
  assign o_tx_busy   = busy_q;
  assign o_tx_done   = done_q;

endmodule
